// File: rtl/wb_xbar_pkg.sv
// Shared types and helpers for the registered Wishbone crossbar.
// Decode/owner ids reserve the value N as "none" so they need one extra code point.
package wb_xbar_pkg;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_OWNED = 1'b1} arb_state_e;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Encodings one past the last valid index: the error responder / no owner.
  function automatic int no_target(input int n_targets);
    return n_targets;
  endfunction

  function automatic int no_initiator(input int n_initiators);
    return n_initiators;
  endfunction

  function automatic int unsigned onehot2bin(input logic [63:0] oh);
    int unsigned b;
    b = 0;
    for (int k = 0; k < 64; k++)
      if (oh[k]) b = b | k;
    return b;
  endfunction

endpackage

// File: rtl/wb_xbar_rr_arb.sv
// Per-target round-robin arbiter with bus lock: a grant is held until the owner drops cyc.
// The pointer remembers the last owner; the search starts just after it.
module wb_xbar_rr_arb
  import wb_xbar_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             owner_cyc,
  output logic [N_REQ-1:0] gnt,
  output logic             lock
);
  localparam int IW = id_w(N_REQ);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic             found;
  int               idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      gnt     <= '0;
      ptr_q   <= IW'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Release and re-grant share one edge so back-to-back owners lose no cycle.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = 0;
    if (state_q == ARB_IDLE || !owner_cyc) begin
      state_d = ARB_IDLE;
      gnt_d   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
        idx = (int'(ptr_q) + k) % N_REQ;
        if (!found && req[idx]) begin
          found      = 1'b1;
          gnt_d[idx] = 1'b1;
          ptr_d      = IW'(idx);
          state_d    = ARB_OWNED;
        end
      end
    end
  end

  assign lock = (state_q == ARB_OWNED);

endmodule

// File: rtl/wb_xbar_nxn_reg.sv
// Wishbone NxN crossbar: registered round-robin arbitration with bus lock, unmapped-address
// error responder, per-target watchdog, optional registered response path.
module wb_xbar_nxn_reg
  import wb_xbar_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int N_INITIATORS   = 2,
  parameter int N_TARGETS      = 2,
  parameter logic [N_TARGETS*WB_ADDR_WIDTH-1:0] T_ADR_MASK = {32'hFF00_0000, 32'hFF00_0000},
  parameter logic [N_TARGETS*WB_ADDR_WIDTH-1:0] T_ADR      = {32'h2000_0000, 32'h1000_0000},
  parameter int TIMEOUT_CYCLES = 256,
  parameter bit REG_RSP        = 1'b0
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic [N_INITIATORS-1:0][WB_ADDR_WIDTH-1:0]       adr,
  input  logic [N_INITIATORS-1:0][WB_DATA_WIDTH-1:0]       dat_w,
  output logic [N_INITIATORS-1:0][WB_DATA_WIDTH-1:0]       dat_r,
  input  logic [N_INITIATORS-1:0]                          cyc,
  input  logic [N_INITIATORS-1:0]                          stb,
  input  logic [N_INITIATORS-1:0]                          we,
  input  logic [N_INITIATORS-1:0][WB_DATA_WIDTH/8-1:0]     sel,
  output logic [N_INITIATORS-1:0]                          ack,
  output logic [N_INITIATORS-1:0]                          err,
  output logic [N_TARGETS-1:0][WB_ADDR_WIDTH-1:0]          tadr,
  output logic [N_TARGETS-1:0][WB_DATA_WIDTH-1:0]          tdat_w,
  output logic [N_TARGETS-1:0][WB_DATA_WIDTH/8-1:0]        tsel,
  input  logic [N_TARGETS-1:0][WB_DATA_WIDTH-1:0]          tdat_r,
  output logic [N_TARGETS-1:0]                             tcyc,
  output logic [N_TARGETS-1:0]                             tstb,
  output logic [N_TARGETS-1:0]                             twe,
  input  logic [N_TARGETS-1:0]                             tack,
  input  logic [N_TARGETS-1:0]                             terr
);
  localparam int SW   = WB_DATA_WIDTH / 8;
  localparam int TW   = id_w(N_TARGETS + 1);
  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0]   NO_T   = TW'(no_target(N_TARGETS));
  localparam logic [WD_W-1:0] WD_LIM = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [N_INITIATORS-1:0][TW-1:0]            dec_id;
  logic [N_INITIATORS-1:0]                    unmapped, erq;
  logic [N_TARGETS-1:0][N_INITIATORS-1:0]     route;
  logic [N_TARGETS-1:0]                       rsp_ack, rsp_err;
  logic [N_INITIATORS-1:0]                    ack_c, err_c;
  logic [N_INITIATORS-1:0][WB_DATA_WIDTH-1:0] dat_c;

  // Descending scan so the lowest matching target wins overlapping windows.
  always_comb begin
    for (int i = 0; i < N_INITIATORS; i++) begin
      dec_id[i] = NO_T;
      for (int t = N_TARGETS - 1; t >= 0; t--)
        if ((adr[i] & T_ADR_MASK[t*WB_ADDR_WIDTH +: WB_ADDR_WIDTH]) ==
            T_ADR[t*WB_ADDR_WIDTH +: WB_ADDR_WIDTH])
          dec_id[i] = TW'(t);
      unmapped[i] = cyc[i] & stb[i] & (dec_id[i] == NO_T);
    end
  end

  for (genvar t = 0; t < N_TARGETS; t++) begin : g_tgt
    logic [N_INITIATORS-1:0]  req, gnt;
    logic                     lock, own_cyc, own_req, f_we, t_stb, timeout, mask_q;
    logic [WB_ADDR_WIDTH-1:0] f_adr;
    logic [WB_DATA_WIDTH-1:0] f_dat;
    logic [SW-1:0]            f_sel;
    logic [WD_W-1:0]          wd_cnt;

    for (genvar i = 0; i < N_INITIATORS; i++) begin : g_req
      assign req[i]      = cyc[i] & stb[i] & (dec_id[i] == TW'(t));
      assign route[t][i] = gnt[i] & (dec_id[i] == TW'(t));
    end

    wb_xbar_rr_arb #(.N_REQ(N_INITIATORS)) u_arb (
      .clk(clk), .rst_n(rst_n), .req(req), .owner_cyc(own_cyc), .gnt(gnt), .lock(lock)
    );

    always_comb begin
      own_cyc = 1'b0;
      own_req = 1'b0;
      f_we    = 1'b0;
      f_adr   = '0;
      f_dat   = '0;
      f_sel   = '0;
      for (int i = 0; i < N_INITIATORS; i++)
        if (gnt[i]) begin
          own_cyc = cyc[i];
          own_req = req[i];
          if (dec_id[i] == TW'(t)) begin
            f_we  = we[i];
            f_adr = adr[i];
            f_dat = dat_w[i];
            f_sel = sel[i];
          end
        end
    end

    assign t_stb   = own_req & ~mask_q;
    assign timeout = (TIMEOUT_CYCLES != 0) && t_stb && !tack[t] && !terr[t] && (wd_cnt == WD_LIM);

    // mask_q hides one strobe after a timeout, or after a termination when the response is
    // registered, so the target never sees the same access twice.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wd_cnt <= '0;
        mask_q <= 1'b0;
      end else begin
        mask_q <= timeout | (REG_RSP && t_stb && (tack[t] | terr[t]));
        if (tack[t] || terr[t] || !t_stb || timeout) wd_cnt <= '0;
        else                                          wd_cnt <= wd_cnt + 1'b1;
      end
    end

    assign tcyc[t]   = lock & own_cyc;
    assign tstb[t]   = t_stb;
    assign twe[t]    = f_we;
    assign tadr[t]   = f_adr;
    assign tdat_w[t] = f_dat;
    assign tsel[t]   = f_sel;
    assign rsp_ack[t] = tack[t] & ~terr[t];
    assign rsp_err[t] = terr[t] | timeout;
  end

  always_comb begin
    ack_c = '0;
    err_c = '0;
    dat_c = '0;
    for (int i = 0; i < N_INITIATORS; i++)
      for (int t = 0; t < N_TARGETS; t++)
        if (route[t][i]) begin
          ack_c[i] = ack_c[i] | rsp_ack[t];
          err_c[i] = err_c[i] | rsp_err[t];
          dat_c[i] = dat_c[i] | tdat_r[t];
        end
  end

  // One-cycle error pulse; with stb held it re-fires every second cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) erq <= '0;
    else        erq <= unmapped & ~erq;
  end

  if (REG_RSP) begin : g_reg_rsp
    logic [N_INITIATORS-1:0]                    ack_q, err_q;
    logic [N_INITIATORS-1:0][WB_DATA_WIDTH-1:0] dat_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ack_q <= '0;
        err_q <= '0;
        dat_q <= '0;
      end else begin
        ack_q <= ack_c;
        err_q <= err_c;
        dat_q <= dat_c;
      end
    end
    assign ack   = ack_q;
    assign err   = err_q | erq;
    assign dat_r = dat_q;
  end else begin : g_comb_rsp
    assign ack   = ack_c;
    assign err   = err_c | erq;
    assign dat_r = dat_c;
  end

endmodule

// File: tb/tb_wb_xbar_nxn_reg.sv
// Directed bench for wb_xbar_nxn_reg: u0 has a combinational response path, u1 a registered one.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_wb_xbar_nxn_reg;
  localparam int AW = 32, DW = 32, NI = 2, NT = 2;
  localparam logic [NT*AW-1:0] MASKS = {32'hFF00_0000, 32'hFF00_0000};
  localparam logic [NT*AW-1:0] BASES = {32'h2000_0000, 32'h1000_0000};

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0][AW-1:0]   adr;
  logic [NI-1:0][DW-1:0]   dat_w;
  logic [NI-1:0]           cyc, stb, we;
  logic [NI-1:0][DW/8-1:0] sel;
  logic [NT-1:0][DW-1:0]   tdat_r;
  logic [NT-1:0]           tack, terr;

  logic [NI-1:0][DW-1:0]   dat_r0, dat_r1;
  logic [NI-1:0]           ack0, err0, ack1, err1;
  logic [NT-1:0][AW-1:0]   tadr0, tadr1;
  logic [NT-1:0][DW-1:0]   tdat_w0, tdat_w1;
  logic [NT-1:0][DW/8-1:0] tsel0, tsel1;
  logic [NT-1:0]           tcyc0, tstb0, twe0, tcyc1, tstb1, twe1;

  int checks = 0, errors = 0;

  wb_xbar_nxn_reg #(.WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .N_INITIATORS(NI), .N_TARGETS(NT),
    .T_ADR_MASK(MASKS), .T_ADR(BASES), .TIMEOUT_CYCLES(8), .REG_RSP(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .adr(adr), .dat_w(dat_w), .dat_r(dat_r0), .cyc(cyc), .stb(stb),
    .we(we), .sel(sel), .ack(ack0), .err(err0), .tadr(tadr0), .tdat_w(tdat_w0), .tsel(tsel0),
    .tdat_r(tdat_r), .tcyc(tcyc0), .tstb(tstb0), .twe(twe0), .tack(tack), .terr(terr));

  wb_xbar_nxn_reg #(.WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .N_INITIATORS(NI), .N_TARGETS(NT),
    .T_ADR_MASK(MASKS), .T_ADR(BASES), .TIMEOUT_CYCLES(8), .REG_RSP(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .adr(adr), .dat_w(dat_w), .dat_r(dat_r1), .cyc(cyc), .stb(stb),
    .we(we), .sel(sel), .ack(ack1), .err(err1), .tadr(tadr1), .tdat_w(tdat_w1), .tsel(tsel1),
    .tdat_r(tdat_r), .tcyc(tcyc1), .tstb(tstb1), .twe(twe1), .tack(tack), .terr(terr));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cyc = '0; stb = '0; we = '0; adr = '0; dat_w = '0; sel = '0;
    tack = '0; terr = '0; tdat_r = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: grant, then async reset mid-transaction, then tie after release
    nxt(); cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 32'h1000_0004; sel[0] = 4'hF; dat_w[0] = 32'h55AA;
    smp(); chk("t1_pregrant_tcyc", tcyc0, 2'b00);
    nxt(); smp();
    chk("t1_tcyc", tcyc0, 2'b01);
    chk("t1_tstb", tstb0, 2'b01);
    chk("t1_tadr", tadr0[0], 32'h1000_0004);
    chk("t1_twe", twe0, 2'b01);
    chk("t1_tdat_w", tdat_w0[0], 32'h55AA);
    #1 rst_n = 1'b0; tack[0] = 1; tdat_r[0] = 32'h1111;
    #2;
    chk("t1_rst_tcyc", tcyc0, 2'b00);
    chk("t1_rst_tstb", tstb0, 2'b00);
    chk("t1_rst_tadr", tadr0[0], 32'h0);
    chk("t1_rst_ack", ack0, 2'b00);
    chk("t1_rst_dat_r", dat_r0[0], 32'h0);
    nxt(); rst_n = 1'b1; we = '0; cyc[1] = 1; stb[1] = 1; adr[1] = 32'h1000_0008;
    smp(); chk("t1_release_tcyc", tcyc0, 2'b00);
    chk("t1_release_ack", ack0, 2'b00);
    nxt(); smp();
    chk("t1_tie_owner", tadr0[0], 32'h1000_0004);
    chk("t1_tie_ack", ack0, 2'b01);
    chk("t1_tie_dat_r0", dat_r0[0], 32'h1111);
    chk("t1_tie_dat_r1", dat_r0[1], 32'h0);

    // 2: I1 granted on the edge I0 drops cyc, then round robin over 10 rounds
    nxt(); cyc[0] = 0; stb[0] = 0; tack[0] = 0;
    smp(); chk("t2_drop_tcyc", tcyc0[0], 1'b0);
    nxt(); tack[0] = 1;
    smp(); chk("t2_b2b_owner", tadr0[0], 32'h1000_0008);
    chk("t2_b2b_ack", ack0, 2'b10);
    nxt(); cyc = '0; stb = '0; tack = '0;
    for (int r = 0; r < 10; r++) begin
      nxt(); cyc = 2'b11; stb = 2'b11; adr[0] = 32'h1000_0004; adr[1] = 32'h1000_0008;
      nxt(); smp();
      chk($sformatf("t2_rr%0d", r), tadr0[0], (r % 2 == 0) ? 32'h1000_0004 : 32'h1000_0008);
      nxt(); cyc = '0; stb = '0;
    end

    // 3: I0 locks T0 over three strobes while I1 stalls
    nxt(); cyc[0] = 1; stb[0] = 1;
    nxt(); cyc[1] = 1; stb[1] = 1; tack[0] = 1;
    smp(); chk("t3_ack_a", ack0, 2'b01);
    nxt(); stb[0] = 0; tack[0] = 0;
    smp(); chk("t3_gap_tstb", tstb0[0], 1'b0);
    chk("t3_gap_tcyc", tcyc0[0], 1'b1);
    chk("t3_gap_ack", ack0, 2'b00);
    nxt(); stb[0] = 1; tack[0] = 1;
    smp(); chk("t3_ack_b", ack0, 2'b01);
    nxt(); stb[0] = 0; tack[0] = 0;
    smp(); chk("t3_stall_ack", ack0, 2'b00);
    nxt(); stb[0] = 1; tack[0] = 1;
    smp(); chk("t3_ack_c", ack0, 2'b01);
    chk("t3_still_i0", tadr0[0], 32'h1000_0004);
    nxt(); cyc[0] = 0; stb[0] = 0; tack[0] = 0;
    smp(); chk("t3_drop_tcyc", tcyc0[0], 1'b0);
    nxt(); tack[0] = 1;
    smp(); chk("t3_i1_owner", tadr0[0], 32'h1000_0008);
    chk("t3_i1_ack", ack0, 2'b10);
    nxt(); clr();

    // 4: unmapped access -> one-cycle err pulses, no target traffic
    nxt(); cyc[1] = 1; stb[1] = 1; adr[1] = 32'h3000_0000;
    smp(); chk("t4_err_early", err0, 2'b00);
    chk("t4_tcyc_a", tcyc0, 2'b00);
    nxt(); smp();
    chk("t4_err", err0, 2'b10);
    chk("t4_no_ack", ack0, 2'b00);
    chk("t4_tcyc_b", tcyc0, 2'b00);
    nxt(); smp(); chk("t4_err_gap", err0, 2'b00);
    nxt(); smp(); chk("t4_err_repeat", err0, 2'b10);
    nxt(); clr();

    // 5: watchdog on T1, restart, tack beats timeout, terr beats tack
    nxt(); cyc[0] = 1; stb[0] = 1; adr[0] = 32'h2000_0000;
    for (int k = 1; k <= 8; k++) begin
      nxt(); smp();
      chk($sformatf("t5_wd%0d", k), err0, (k == 8) ? 2'b01 : 2'b00);
    end
    nxt(); smp();
    chk("t5_mask_tstb", tstb0[1], 1'b0);
    chk("t5_mask_tcyc", tcyc0[1], 1'b1);
    chk("t5_mask_err", err0, 2'b00);
    for (int k = 1; k <= 8; k++) begin
      nxt(); if (k == 8) tack[1] = 1;
      smp();
      chk($sformatf("t5_re%0d_err", k), err0, 2'b00);
    end
    chk("t5_tack_wins", ack0, 2'b01);
    nxt(); tack[1] = 1; terr[1] = 1;
    smp(); chk("t5_nomask", tstb0[1], 1'b1);
    chk("t5_err_wins_err", err0, 2'b01);
    chk("t5_err_wins_ack", ack0, 2'b00);
    nxt(); clr();

    // 6: registered response path
    nxt(); rst_n = 1'b0;
    nxt(); rst_n = 1'b1;
    nxt(); cyc[0] = 1; stb[0] = 1; adr[0] = 32'h1000_0000;
    nxt(); tack[0] = 1; tdat_r[0] = 32'hCAFE_F00D;
    smp(); chk("t6_tstb", tstb1[0], 1'b1);
    chk("t6_ack_early", ack1, 2'b00);
    nxt(); tack[0] = 0; tdat_r[0] = '0;
    smp(); chk("t6_ack", ack1, 2'b01);
    chk("t6_dat_r", dat_r1[0], 32'hCAFE_F00D);
    chk("t6_tstb_masked", tstb1[0], 1'b0);
    chk("t6_tcyc", tcyc1[0], 1'b1);
    nxt(); smp();
    chk("t6_single_ack", ack1, 2'b00);
    chk("t6_tstb_back", tstb1[0], 1'b1);
    nxt(); clr();
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
